uart_multi_timer: RTL and testbench



---
 rtl/uart_timer_pkg.sv | 11 +
 rtl/uart_timer_channel.sv | 78 +++++++
 rtl/uart_multi_timer.sv | 55 +++++
 tb/tb_uart_multi_timer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_timer_pkg.sv
// Shared constants for the UART multi-channel interval timer.
// Holds the channel state encodings and the counting mode encodings.
package uart_timer_pkg;

   localparam logic [0:0] ST_IDLE       = 1'b0;
   localparam logic [0:0] ST_RUN        = 1'b1;

   localparam logic [0:0] MODE_PERIODIC = 1'b0;
   localparam logic [0:0] MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/uart_timer_channel.sv
// One timer channel: start/stop control, shadowed limit, periodic or one-shot
// counting on the shared tick, registered done/busy/count outputs.
module uart_timer_channel
   import uart_timer_pkg::*;
#(
   parameter int BITS = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick,
   input  logic            start,
   input  logic            stop,
   input  logic            oneshot,
   input  logic [BITS-1:0] limit,
   output logic            done,
   output logic            busy,
   output logic [BITS-1:0] count
);

   logic [0:0]      state_r;
   logic [0:0]      mode_r;
   logic [BITS-1:0] shadow_r;
   logic [BITS-1:0] count_r;
   logic            done_r;

   // Channel state machine; stop beats start, and start beats a same-cycle wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         mode_r   <= MODE_PERIODIC;
         shadow_r <= {BITS{1'b0}};
         count_r  <= {BITS{1'b0}};
         done_r   <= 1'b0;
      end else if (stop) begin
         state_r  <= ST_IDLE;
         count_r  <= {BITS{1'b0}};
         done_r   <= 1'b0;
      end else if (start) begin
         state_r  <= ST_RUN;
         count_r  <= {BITS{1'b0}};
         shadow_r <= limit;
         mode_r   <= oneshot ? MODE_ONESHOT : MODE_PERIODIC;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               if (tick) begin
                  if (count_r == shadow_r) begin
                     count_r <= {BITS{1'b0}};
                     done_r  <= 1'b1;
                     // Periodic channels pick up a new limit only here, at the wrap.
                     if (mode_r == MODE_PERIODIC) begin
                        shadow_r <= limit;
                     end else begin
                        state_r  <= ST_IDLE;
                     end
                  end else begin
                     count_r <= count_r + BITS'(1);
                  end
               end
            end
            ST_IDLE: begin
               count_r <= {BITS{1'b0}};
            end
            default: begin
               state_r <= ST_IDLE;
               count_r <= {BITS{1'b0}};
            end
         endcase
      end
   end

   assign done  = done_r;
   assign busy  = (state_r == ST_RUN);
   assign count = count_r;

endmodule

// File: rtl/uart_multi_timer.sv
// Multi-channel programmable interval timer: a free-running shared prescaler
// feeding CHANNELS independent timer channels.
module uart_multi_timer
   import uart_timer_pkg::*;
#(
   parameter int BITS     = 16,
   parameter int CHANNELS = 2,
   parameter int PRE_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PRE_BITS-1:0]      prescale,
   input  logic [CHANNELS-1:0]      start,
   input  logic [CHANNELS-1:0]      stop,
   input  logic [CHANNELS-1:0]      oneshot,
   input  logic [CHANNELS*BITS-1:0] limit,
   output logic [CHANNELS-1:0]      done,
   output logic [CHANNELS-1:0]      busy,
   output logic [CHANNELS*BITS-1:0] count
);

   logic [PRE_BITS-1:0] pcnt_r;
   logic                tick;

   assign tick = (pcnt_r == {PRE_BITS{1'b0}});

   // Prescaler down-counter; start does not touch it, so tick phase is global.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_r <= {PRE_BITS{1'b0}};
      end else if (tick) begin
         pcnt_r <= prescale;
      end else begin
         pcnt_r <= pcnt_r - PRE_BITS'(1);
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      uart_timer_channel #(
         .BITS (BITS)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .tick    (tick),
         .start   (start[i]),
         .stop    (stop[i]),
         .oneshot (oneshot[i]),
         .limit   (limit[i*BITS +: BITS]),
         .done    (done[i]),
         .busy    (busy[i]),
         .count   (count[i*BITS +: BITS])
      );
   end

endmodule

// File: tb/tb_uart_multi_timer.sv
// Self-checking bench for uart_multi_timer: directed scenarios plus random
// stimulus compared against a tick/period reference model.
module tb_uart_multi_timer;

   localparam int BITS = 16;
   localparam int CH   = 2;
   localparam int PB   = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic [PB-1:0]      prescale;
   logic [CH-1:0]      start, stop, oneshot;
   logic [CH*BITS-1:0] limit;
   logic [CH-1:0]      done, busy;
   logic [CH*BITS-1:0] count;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: ticks counted inside a period of (limit+1) ticks.
   int m_pcnt;
   bit m_run    [CH];
   bit m_one    [CH];
   bit m_done   [CH];
   int m_phase  [CH];
   int m_period [CH];

   uart_multi_timer #(.BITS(BITS), .CHANNELS(CH), .PRE_BITS(PB)) dut (
      .clk(clk), .reset(reset), .prescale(prescale), .start(start), .stop(stop),
      .oneshot(oneshot), .limit(limit), .done(done), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [CH*(BITS+2)-1:0] expv();
      logic [CH-1:0]      d, b;
      logic [CH*BITS-1:0] c;
      for (int i = 0; i < CH; i++) begin
         d[i] = m_done[i];
         b[i] = m_run[i];
         c[i*BITS +: BITS] = BITS'(m_phase[i]);
      end
      return {d, b, c};
   endfunction

   task automatic cycle();
      bit t;
      @(posedge clk);
      if (reset) begin
         m_pcnt = 0;
         for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_phase[i] = 0; m_done[i] = 0; m_one[i] = 0; m_period[i] = 1;
         end
      end else begin
         t = (m_pcnt == 0);
         m_pcnt = t ? int'(prescale) : m_pcnt - 1;
         for (int i = 0; i < CH; i++) begin
            m_done[i] = 0;
            if (stop[i]) begin
               m_run[i] = 0; m_phase[i] = 0;
            end else if (start[i]) begin
               m_run[i] = 1; m_phase[i] = 0; m_one[i] = oneshot[i];
               m_period[i] = int'(limit[i*BITS +: BITS]) + 1;
            end else if (m_run[i] && t) begin
               m_phase[i]++;
               if (m_phase[i] == m_period[i]) begin
                  m_phase[i] = 0;
                  m_done[i]  = 1;
                  if (m_one[i]) m_run[i] = 0;
                  else m_period[i] = int'(limit[i*BITS +: BITS]) + 1;
               end
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = '0; stop = '0; oneshot = '0; limit = '0; prescale = '0;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = '1; stop = '0; oneshot = '0; limit = '1; prescale = 8'd3;
      cycle();
      n_checks++;
      if ({done, busy, count} !== {(CH*(BITS+2)){1'b0}})
         $display("FAIL reset: got done=%b busy=%b count=%h want all zero", done, busy, count);
      else n_pass++;
      reset = 1'b0; start = '0;
   endtask

   task automatic test_periodic();
      do_reset();
      limit[15:0] = 16'd3; start = 2'b01;
      cycle();
      start = '0;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         n_checks++;
         if (done[0] !== (k % 4 == 0) || count[15:0] !== 16'(k % 4) || busy[0] !== 1'b1)
            $display("FAIL periodic edge %0d: got done=%b count=%0d busy=%b want done=%b count=%0d busy=1",
                     k, done[0], count[15:0], busy[0], (k % 4 == 0), k % 4);
         else n_pass++;
      end
   endtask

   task automatic test_oneshot();
      do_reset();
      limit[31:16] = 16'd5; oneshot = 2'b10; start = 2'b10;
      cycle();
      start = '0; oneshot = '0;
      for (int k = 1; k <= 9; k++) begin
         cycle();
         n_checks++;
         if (done[1] !== (k == 6) || busy[1] !== (k < 6) || count[31:16] !== 16'((k < 6) ? k : 0))
            $display("FAIL oneshot edge %0d: got done=%b busy=%b count=%0d want done=%b busy=%b",
                     k, done[1], busy[1], count[31:16], (k == 6), (k < 6));
         else n_pass++;
      end
   endtask

   task automatic test_prescale();
      int last = -1;
      do_reset();
      prescale = 8'd2; limit[15:0] = 16'd1; start = 2'b01;
      cycle();
      start = '0;
      for (int k = 1; k <= 30; k++) begin
         cycle();
         n_checks++;
         if ({done, busy, count} !== expv())
            $display("FAIL prescale edge %0d: got %h want %h", k, {done, busy, count}, expv());
         else n_pass++;
         if (done[0]) begin
            if (last >= 0) begin
               n_checks++;
               if (k - last !== 6)
                  $display("FAIL prescale spacing: got %0d clocks want 6", k - last);
               else n_pass++;
            end
            last = k;
         end
      end
   endtask

   task automatic test_limit_change();
      do_reset();
      limit[15:0] = 16'd3; start = 2'b01;
      cycle();
      start = '0;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 1) limit[15:0] = 16'd1;
         n_checks++;
         if (done[0] !== (k == 4 || k == 6 || k == 8))
            $display("FAIL limit_change edge %0d: got done=%b want %b", k, done[0], (k == 4 || k == 6 || k == 8));
         else n_pass++;
      end
   endtask

   task automatic test_stop_start();
      do_reset();
      limit[15:0] = 16'd3; start = 2'b01;
      cycle();
      start = '0;
      cycle(); cycle();
      start = 2'b01; stop = 2'b01;
      cycle();
      start = '0; stop = '0;
      n_checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || count[15:0] !== 16'd0)
         $display("FAIL start_stop: got done=%b busy=%b count=%0d want 0 0 0", done[0], busy[0], count[15:0]);
      else n_pass++;
      start = 2'b01;
      cycle();
      start = '0;
      cycle(); cycle(); cycle();
      start = 2'b01;
      cycle();
      start = '0;
      n_checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b1 || count[15:0] !== 16'd0)
         $display("FAIL restart_on_wrap: got done=%b busy=%b count=%0d want 0 1 0", done[0], busy[0], count[15:0]);
      else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         n_checks++;
         if ({done, busy, count} !== expv())
            $display("FAIL after_restart edge %0d: got %h want %h", k, {done, busy, count}, expv());
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      limit = {16'd9, 16'd7}; start = 2'b11;
      cycle();
      start = '0;
      cycle(); cycle(); cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      n_checks++;
      if ({done, busy, count} !== {(CH*(BITS+2)){1'b0}})
         $display("FAIL reset_mid: got done=%b busy=%b count=%h want all zero", done, busy, count);
      else n_pass++;
   endtask

   task automatic test_limit0();
      do_reset();
      limit[15:0] = 16'd0; start = 2'b01;
      cycle();
      start = '0;
      for (int k = 1; k <= 5; k++) begin
         cycle();
         n_checks++;
         if (done[0] !== 1'b1)
            $display("FAIL limit0 edge %0d: got done=%b want 1", k, done[0]);
         else n_pass++;
      end
      stop = 2'b01;
      cycle();
      stop = '0;
      n_checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0)
         $display("FAIL limit0_stop: got done=%b busy=%b want 0 0", done[0], busy[0]);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) prescale = PB'($urandom_range(0, 3));
         for (int i = 0; i < CH; i++) begin
            start[i]   = ($urandom_range(0, 15) == 0);
            stop[i]    = ($urandom_range(0, 39) == 0);
            oneshot[i] = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) limit[i*BITS +: BITS] = BITS'($urandom_range(0, 6));
         end
         cycle();
         n_checks++;
         if ({done, busy, count} !== expv())
            $display("FAIL random cycle %0d: got done=%b busy=%b count=%h want %h", k, done, busy, count, expv());
         else n_pass++;
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = '0; stop = '0; oneshot = '0; limit = '0; prescale = '0;
      test_reset();
      test_periodic();
      test_oneshot();
      test_prescale();
      test_limit_change();
      test_stop_start();
      test_reset_mid();
      test_limit0();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
